// File: rtl/taillights_pkg.sv
// Shared types and constants for the taillight sequencing controller.
package taillights_pkg;

   typedef enum logic [2:0] {
      M_OFF    = 3'd0,
      M_LEFT   = 3'd1,
      M_RIGHT  = 3'd2,
      M_HAZARD = 3'd3,
      M_LAMP   = 3'd4
   } mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      LAMP = 2'd2
   } ctrl_state_t;

   localparam logic [1:0] FRAME_OFF = 2'd0;
   localparam logic [1:0] FRAME_ALL = 2'd3;

   // Hazard, or both levers at once, outranks a single turn request.
   function automatic mode_t resolve_req(input logic left, input logic right, input logic hazard);
      if (hazard || (left && right)) return M_HAZARD;
      else if (left)                 return M_LEFT;
      else if (right)                return M_RIGHT;
      return M_OFF;
   endfunction

endpackage

// File: rtl/taillights_prescaler.sv
// Step prescaler: counts 0..TICK_DIV-1 while enabled, tick in the terminal-count cycle.
module taillights_prescaler #(
   parameter int TICK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int            CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= (cnt_q == TC) ? '0 : cnt_q + CW'(1);
      end
   end

   assign tick_o = en_i && (cnt_q == TC);

endmodule

// File: rtl/taillights_ctrl.sv
// Taillight sequencing controller: resolves requests into a lighting mode and steps frames.
//
//   state | meaning
//   IDLE  | lamps off, prescaler held at 0, waiting for a request or lamp test
//   RUN   | sequencing frames 0..3 of the current turn/hazard mode
//   LAMP  | lamp test: all lamps and brake lit for LAMP_STEPS steps
module taillights_ctrl
   import taillights_pkg::*;
#(
   parameter int TICK_DIV   = 4,
   parameter int LAMP_STEPS = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       left_i,
   input  logic       right_i,
   input  logic       hazard_i,
   input  logic       brake_i,
   input  logic       lamp_test_i,
   output mode_t      mode_o,
   output logic [1:0] frame_o,
   output logic       step_o,
   output logic       brake_o,
   output logic       active_o
);

   localparam int            LW        = $clog2(LAMP_STEPS + 1);
   localparam logic [LW-1:0] LAMP_LAST = LW'(LAMP_STEPS - 1);

   ctrl_state_t   state_q, state_d;
   mode_t         mode_q, mode_d;
   logic [1:0]    frame_q, frame_d;
   logic          step_q, step_d;
   logic          brake_q, brake_d;
   logic [LW-1:0] lamp_cnt_q, lamp_cnt_d;
   logic          lamp_test_q;

   mode_t req;
   logic  lt_rise;
   logic  tick;
   logic  pre_clr;
   logic  pre_en;

   assign req     = resolve_req(left_i, right_i, hazard_i);
   assign lt_rise = lamp_test_i & ~lamp_test_q;

   // Restart the cadence on every state change so each mode begins a full step.
   assign pre_en  = (state_q != IDLE);
   assign pre_clr = (state_q == IDLE) || (state_d != state_q);

   taillights_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (pre_clr),
      .en_i   (pre_en),
      .tick_o (tick)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         mode_q      <= M_OFF;
         frame_q     <= FRAME_OFF;
         step_q      <= 1'b0;
         brake_q     <= 1'b0;
         lamp_cnt_q  <= '0;
         lamp_test_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         frame_q     <= frame_d;
         step_q      <= step_d;
         brake_q     <= brake_d;
         lamp_cnt_q  <= lamp_cnt_d;
         lamp_test_q <= lamp_test_i;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (lt_rise)             state_d = LAMP;
            else if (req != M_OFF)   state_d = RUN;
         end
         RUN: begin
            if (lt_rise)                                           state_d = LAMP;
            else if (tick && frame_q == FRAME_ALL && req == M_OFF) state_d = IDLE;
         end
         LAMP: begin
            if (tick && lamp_cnt_q == LAMP_LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mode_d     = mode_q;
      frame_d    = frame_q;
      step_d     = 1'b0;
      lamp_cnt_d = lamp_cnt_q;
      unique case (state_q)
         IDLE: begin
            mode_d  = M_OFF;
            frame_d = FRAME_OFF;
            if (lt_rise) begin
               mode_d     = M_LAMP;
               frame_d    = FRAME_ALL;
               lamp_cnt_d = '0;
            end else if (req != M_OFF) begin
               mode_d = req;
            end
         end
         RUN: begin
            if (lt_rise) begin
               mode_d     = M_LAMP;
               frame_d    = FRAME_ALL;
               lamp_cnt_d = '0;
            end else if (tick) begin
               step_d = 1'b1;
               // Mode changes other than hazard preemption wait for the sequence boundary.
               if (frame_q == FRAME_ALL) begin
                  mode_d  = req;
                  frame_d = FRAME_OFF;
               end else if (req == M_HAZARD && mode_q != M_HAZARD) begin
                  mode_d  = M_HAZARD;
                  frame_d = FRAME_OFF;
               end else begin
                  frame_d = frame_q + 2'd1;
               end
            end
         end
         LAMP: begin
            if (tick) begin
               step_d = 1'b1;
               if (lamp_cnt_q == LAMP_LAST) begin
                  mode_d     = M_OFF;
                  frame_d    = FRAME_OFF;
                  lamp_cnt_d = '0;
               end else begin
                  lamp_cnt_d = lamp_cnt_q + LW'(1);
               end
            end
         end
         default: begin
            mode_d  = M_OFF;
            frame_d = FRAME_OFF;
         end
      endcase
      brake_d  = brake_i | (state_d == LAMP);
      active_o = (state_q != IDLE);
   end

   assign mode_o  = mode_q;
   assign frame_o = frame_q;
   assign step_o  = step_q;
   assign brake_o = brake_q;

endmodule

// File: doc/taillights_ctrl.md
# taillights_ctrl

Sequencing controller for the taillight FSM. It registers the driver's lever, hazard, brake and lamp-test requests and resolves conflicting ones into a single lighting mode. It generates the step cadence from a prescaler, keeps a frame index, and changes turn mode only on sequence boundaries. Its outputs (mode, frame, step pulse, brake) feed the `state_t`-based taillight FSM, which decodes them into lamp patterns.

## Interface
- `TICK_DIV`, default 4: clock cycles per sequence step; legal range ≥ 2.
- `LAMP_STEPS`, default 2: number of steps the lamp test lasts; legal range ≥ 1.
- `clk_i`  in  1  single system clock; all logic on its rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `left_i`  in  1  left-turn lever; already debounced and synchronous.
- `right_i`  in  1  right-turn lever.
- `hazard_i`  in  1  hazard switch.
- `brake_i`  in  1  brake pedal.
- `lamp_test_i`  in  1  lamp-test request; acts on its rising edge only.
- `mode_o`  out  3  `mode_t`: `M_OFF`, `M_LEFT`, `M_RIGHT`, `M_HAZARD`, `M_LAMP`.
- `frame_o`  out  2  frame index within the sequence, 0..3. Frame 0 = off, 1 = inner lamp, 2 = inner two lamps, 3 = all three.
- `step_o`  out  1  one-cycle pulse in the cycle that `frame_o`/`mode_o` take new values.
- `brake_o`  out  1  registered brake.
- `active_o`  out  1  high whenever the controller is not in `IDLE`.

## Operation
- Request resolution (combinational, `req`):
  - `hazard_i | (left_i & right_i)` → `M_HAZARD`
  - else `left_i` → `M_LEFT`
  - else `right_i` → `M_RIGHT`
  - else `M_OFF`
- `lt_rise` = `lamp_test_i & ~lamp_test_q`, where `lamp_test_q` is the previous-cycle copy.
- Controller FSM (`ctrl_state_t`) has three states: `IDLE`, `RUN`, `LAMP`.
- `IDLE`:
  - `mode_o=M_OFF`, `frame_o=0`, prescaler held at 0.
  - `lt_rise` → `LAMP`.
  - Otherwise, if `req≠M_OFF` → `RUN` with `mode_o<=req`, `frame_o<=0`, prescaler cleared.
  - `lt_rise` wins if both occur in the same cycle.
- `RUN`: the prescaler counts 0..`TICK_DIV`-1. At terminal count, `step_o` pulses and exactly one of the following applies, in priority order:
  - `frame_o==3` and `req==M_OFF` → `IDLE`, `mode_o<=M_OFF`, `frame_o<=0`.
  - `frame_o==3` (wrap) → `mode_o<=req`, `frame_o<=0`. Turn changes and hazard release happen only here.
  - `req==M_HAZARD` and `mode_o≠M_HAZARD` → preempt: `mode_o<=M_HAZARD`, `frame_o<=0`.
  - Otherwise → `frame_o<=frame_o+1`.
- `lt_rise` in any cycle of `RUN` → `LAMP` on the next edge. This aborts the sequence.
- `LAMP`:
  - On entry: `mode_o=M_LAMP`, `frame_o=3`, `brake_o=1`, prescaler cleared.
  - Counts `LAMP_STEPS` steps, pulsing `step_o` on each one.
  - On the final step → `IDLE`, `mode_o<=M_OFF`, `frame_o<=0`.
  - `lt_rise` during `LAMP` is ignored. Re-entry requires `lamp_test_i` to go low and then high again.
- `brake_o` = `brake_i` delayed one cycle, except forced to 1 while in `LAMP`. Brake never affects sequencing.
- Request levels between steps are not latched. Only the value of `req` in the terminal-count cycle matters.

## Timing
- Reset values: state `IDLE`, `mode_o=M_OFF`, `frame_o=0`, `step_o=0`, `brake_o=0`, `active_o=0`, prescaler 0, lamp counter 0, `lamp_test_q=0`.
- Reset asserted mid-sequence or mid-lamp-test returns all of the above on the next edge.
- Request latency: request present in cycle N → `mode_o`/`active_o` update at edge N+1. The first `step_o` fires `TICK_DIV` cycles after entering `RUN`.
- Step spacing: `step_o` is exactly one cycle wide. Successive pulses are exactly `TICK_DIV` cycles apart while in `RUN` or `LAMP`.
- Width rules:
  - Prescaler width is `$clog2(TICK_DIV)`; it wraps to 0 at `TICK_DIV`-1.
  - `frame_o` wraps 3→0 only by the rules in Operation.
  - Lamp counter width is `$clog2(LAMP_STEPS+1)`.

## Structure
- Add the following to `taillights_pkg`:
  - `mode_t` (3-bit enum).
  - `ctrl_state_t` (2-bit enum: `IDLE`, `RUN`, `LAMP`).
  - Frame constants `FRAME_OFF=0` and `FRAME_ALL=3`.
- One sub-module, `taillights_prescaler`:
  - Parameter `TICK_DIV`; inputs `clk_i`, `rst_i`, `clr_i`, `en_i`; output `tick_o`.
  - `tick_o` is high in the terminal-count cycle.
- The request resolver, edge detector, frame counter and FSM stay in `taillights_ctrl`.

## Test plan
All scenarios use `TICK_DIV=4`, `LAMP_STEPS=2`.
1. Reset, then hold `left_i=1` → `mode_o=M_LEFT` one cycle later. `step_o` at cycles 5, 9, 13, 17 after the request. `frame_o` goes 0→1→2→3→0 and keeps looping.
2. Running `M_LEFT`, `frame_o=1`: drop `left_i`, raise `right_i` → frames 2, 3 stay `M_LEFT`. At the wrap step `mode_o=M_RIGHT`, `frame_o=0`.
3. Running `M_LEFT`, `frame_o=2`: assert `hazard_i` → at the next step `mode_o=M_HAZARD`, `frame_o=0`. Same result for `left_i=right_i=1`.
4. All requests low during `M_RIGHT` at `frame_o=1` → two more steps run. At the wrap step → `IDLE`, `mode_o=M_OFF`, `active_o=0`.
5. Pulse `lamp_test_i` during `RUN` → next edge `mode_o=M_LAMP`, `frame_o=3`, `brake_o=1`. Exactly 2 steps later → `IDLE`. Holding `lamp_test_i` high afterwards does not retrigger.
6. Assert `rst_i` for one cycle mid-`LAMP` with `brake_i=0` → all outputs return to reset values at the next edge. `brake_o` follows `brake_i` with 1-cycle latency afterwards.
